// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the system-bus arbiter.
// Word width sets the per-port packing of address/data buses.
package bus_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request after 'last', wrapping; zero latency.
// No backpressure; vld is low when no request is set.
module rr_select #(
    parameter int NPORTS = 4
) (
    input  logic [NPORTS-1:0]         req,
    input  logic [$clog2(NPORTS)-1:0] last,
    output logic                      vld,
    output logic [$clog2(NPORTS)-1:0] winner
);

    localparam int IDX_W = $clog2(NPORTS);

    always_comb begin
        int              sum;
        logic [IDX_W-1:0] idx;
        vld    = 1'b0;
        winner = '0;
        sum    = 0;
        idx    = '0;
        // Scan last+1 .. last+NPORTS so the previous owner is considered last.
        for (int i = 1; i <= NPORTS; i++) begin
            sum = int'(last) + i;
            if (sum >= NPORTS) begin
                sum = sum - NPORTS;
            end
            idx = IDX_W'(sum);
            if (!vld && req[idx]) begin
                vld    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the single system bus; request->bus 1 cycle, bus ready->o_ready 1 cycle.
// One transaction in flight; others wait on i_request until the owner releases, watchdog aborts stuck slaves.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NPORTS  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [NPORTS-1:0]        i_request,
    input  logic [NPORTS-1:0]        i_rw,
    input  logic [NPORTS*WORD_W-1:0] i_address,
    input  logic [NPORTS*WORD_W-1:0] i_wdata,
    output logic [NPORTS-1:0]        o_ready,
    output logic [NPORTS*WORD_W-1:0] o_rdata,
    output logic                     o_bus_request,
    output logic                     o_bus_rw,
    output logic [WORD_W-1:0]        o_bus_address,
    output logic [WORD_W-1:0]        o_bus_wdata,
    input  logic                     i_bus_ready,
    input  logic [WORD_W-1:0]        i_bus_rdata,
    output logic [NPORTS-1:0]        o_grant,
    output logic                     o_fault
);

    localparam int IDX_W = $clog2(NPORTS);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_req_d, bus_rw_d, fault_d;
    logic [WORD_W-1:0]  bus_addr_d, bus_wdata_d;
    logic [NPORTS-1:0]  ready_d, grant_d;
    logic [WORD_W-1:0]  rdata_q [NPORTS];
    logic [WORD_W-1:0]  rdata_d [NPORTS];
    logic [WORD_W-1:0]  addr_arr [NPORTS];
    logic [WORD_W-1:0]  wdata_arr [NPORTS];
    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        assign addr_arr[g]                = i_address[g*WORD_W +: WORD_W];
        assign wdata_arr[g]               = i_wdata[g*WORD_W +: WORD_W];
        assign o_rdata[g*WORD_W +: WORD_W] = rdata_q[g];
    end

    rr_select #(.NPORTS(NPORTS)) u_rr_select (
        .req    (i_request),
        .last   (last_q),
        .vld    (sel_vld),
        .winner (sel_idx)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        bus_req_d   = o_bus_request;
        bus_rw_d    = o_bus_rw;
        bus_addr_d  = o_bus_address;
        bus_wdata_d = o_bus_wdata;
        grant_d     = o_grant;
        rdata_d     = rdata_q;
        ready_d     = '0;
        fault_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    bus_req_d        = 1'b1;
                    bus_rw_d         = i_rw[sel_idx];
                    bus_addr_d       = addr_arr[sel_idx];
                    bus_wdata_d      = wdata_arr[sel_idx];
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    last_d           = sel_idx;
                    cnt_d            = '0;
                    state_d          = BUSY;
                end
            end
            BUSY: begin
                if (i_bus_ready) begin
                    bus_req_d        = 1'b0;
                    ready_d[last_q]  = 1'b1;
                    rdata_d[last_q]  = i_bus_rdata;
                    state_d          = RELEASE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Slave never answered: complete the owner with zero data and flag it.
                    bus_req_d        = 1'b0;
                    ready_d[last_q]  = 1'b1;
                    rdata_d[last_q]  = '0;
                    fault_d          = 1'b1;
                    state_d          = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!i_request[last_q]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q       <= IDLE;
            last_q        <= IDX_W'(NPORTS - 1);
            cnt_q         <= '0;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
            o_grant       <= '0;
            o_ready       <= '0;
            o_fault       <= 1'b0;
            rdata_q       <= '{default: '0};
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            o_bus_request <= bus_req_d;
            o_bus_rw      <= bus_rw_d;
            o_bus_address <= bus_addr_d;
            o_bus_wdata   <= bus_wdata_d;
            o_grant       <= grant_d;
            o_ready       <= ready_d;
            o_fault       <= fault_d;
            rdata_q       <= rdata_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter: stimulus pushes expected transactions, a monitor checks them.
module tb_bus_arbiter;

    localparam int NP = 4;
    localparam int TO = 16;

    logic            i_clock = 1'b0;
    logic            i_reset;
    logic [NP-1:0]   i_request;
    logic [NP-1:0]   i_rw;
    logic [NP*32-1:0] i_address;
    logic [NP*32-1:0] i_wdata;
    logic [NP-1:0]   o_ready;
    logic [NP*32-1:0] o_rdata;
    logic            o_bus_request;
    logic            o_bus_rw;
    logic [31:0]     o_bus_address;
    logic [31:0]     o_bus_wdata;
    logic            i_bus_ready;
    logic [31:0]     i_bus_rdata;
    logic [NP-1:0]   o_grant;
    logic            o_fault;

    bus_arbiter #(.NPORTS(NP), .TIMEOUT(TO)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_request     (i_request),
        .i_rw          (i_rw),
        .i_address     (i_address),
        .i_wdata       (i_wdata),
        .o_ready       (o_ready),
        .o_rdata       (o_rdata),
        .o_bus_request (o_bus_request),
        .o_bus_rw      (o_bus_rw),
        .o_bus_address (o_bus_address),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_ready   (i_bus_ready),
        .i_bus_rdata   (i_bus_rdata),
        .o_grant       (o_grant),
        .o_fault       (o_fault)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        int          port;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          slv_wait;     // cycles of bus request before slave ready; 0 = never
        logic [31:0] slv_rdata;
        logic [31:0] exp_rdata;
        int          exp_cycles;
        logic        exp_fault;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          reissue [NP];
    logic [NP-1:0] rearm;
    int          slv_cnt;
    logic        stray_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_flag(input string name, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: condition not met", name);
        end
    endtask

    task automatic expect_txn(input int port, input logic rw, input logic [31:0] addr,
                              input logic [31:0] wdata, input int slv_wait,
                              input logic [31:0] slv_rdata, input logic [31:0] exp_rdata,
                              input int exp_cycles, input logic exp_fault);
        exp_t e;
        e.port = port; e.rw = rw; e.addr = addr; e.wdata = wdata;
        e.slv_wait = slv_wait; e.slv_rdata = slv_rdata; e.exp_rdata = exp_rdata;
        e.exp_cycles = exp_cycles; e.exp_fault = exp_fault;
        exp_q.push_back(e);
    endtask

    task automatic raise(input int p, input logic rw, input logic [31:0] addr,
                         input logic [31:0] wdata, input int nre);
        i_rw[p]              = rw;
        i_address[p*32 +: 32] = addr;
        i_wdata[p*32 +: 32]   = wdata;
        reissue[p]           = nre;
        i_request[p]         = 1'b1;
    endtask

    // One cycle of the slave and requester models, driven at the falling edge.
    task automatic tick();
        exp_t cur;
        @(negedge i_clock);
        if (!i_reset) begin
            slv_cnt     = 0;
            i_bus_ready = 1'b0;
        end else if (o_bus_request) begin
            slv_cnt++;
            if (exp_q.size() > 0) begin
                cur         = exp_q[0];
                i_bus_rdata = cur.slv_rdata;
                i_bus_ready = (cur.slv_wait != 0) && (slv_cnt == cur.slv_wait);
            end else begin
                i_bus_ready = 1'b0;
            end
        end else begin
            slv_cnt     = 0;
            i_bus_ready = stray_en;
            i_bus_rdata = 32'hBAD0_BAD0;
        end
        for (int p = 0; p < NP; p++) begin
            if (rearm[p]) begin
                i_request[p] = 1'b1;
                rearm[p]     = 1'b0;
                reissue[p]   = reissue[p] - 1;
            end else if (i_reset && o_ready[p]) begin
                i_request[p] = 1'b0;
                if (reissue[p] > 0) rearm[p] = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || i_request != '0 || rearm != '0) && n < limit) begin
            tick();
            n++;
        end
        chk_flag(name, exp_q.size() == 0 && i_request == '0);
        exp_q.delete();
        repeat (3) tick();
    endtask

    // Monitor: bus-side checks at request rise, stability while held, response checks on o_ready.
    initial begin
        exp_t        e;
        logic        prev_req;
        int          hi_cnt;
        logic        cap_rw;
        logic [31:0] cap_addr, cap_wdata;
        logic [NP-1:0] oh;
        prev_req = 1'b0;
        hi_cnt   = 0;
        cap_rw   = 1'b0;
        cap_addr = '0;
        cap_wdata = '0;
        forever begin
            @(negedge i_clock);
            if (!i_reset) begin
                prev_req = 1'b0;
                hi_cnt   = 0;
            end else begin
                if (o_bus_request) begin
                    if (!prev_req) begin
                        if (exp_q.size() == 0) begin
                            chk_flag("bus_unexpected_request", 1'b0);
                        end else begin
                            e = exp_q[0];
                            oh = '0;
                            oh[e.port] = 1'b1;
                            chk("bus_grant", 32'(o_grant), 32'(oh));
                            chk("bus_rw", 32'(o_bus_rw), 32'(e.rw));
                            chk("bus_addr", o_bus_address, e.addr);
                            if (e.rw) chk("bus_wdata", o_bus_wdata, e.wdata);
                        end
                        cap_rw    = o_bus_rw;
                        cap_addr  = o_bus_address;
                        cap_wdata = o_bus_wdata;
                    end else begin
                        chk("bus_stable_rw", 32'(o_bus_rw), 32'(cap_rw));
                        chk("bus_stable_addr", o_bus_address, cap_addr);
                        chk("bus_stable_wdata", o_bus_wdata, cap_wdata);
                    end
                    hi_cnt++;
                end
                if (o_fault && o_ready == '0) chk_flag("fault_without_ready", 1'b0);
                if (o_ready != '0) begin
                    if (exp_q.size() == 0) begin
                        chk_flag("unexpected_ready", 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        oh = '0;
                        oh[e.port] = 1'b1;
                        chk("ready_port", 32'(o_ready), 32'(oh));
                        chk("ready_grant", 32'(o_grant), 32'(oh));
                        chk("ready_bus_req_low", 32'(o_bus_request), 32'(0));
                        chk("req_cycles", hi_cnt, e.exp_cycles);
                        chk("fault", 32'(o_fault), 32'(e.exp_fault));
                        if (!e.rw) chk("rdata", o_rdata[e.port*32 +: 32], e.exp_rdata);
                    end
                    hi_cnt = 0;
                end
                prev_req = o_bus_request;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus_req"}, 32'(o_bus_request), 32'(0));
        chk({tag, "_bus_rw"}, 32'(o_bus_rw), 32'(0));
        chk({tag, "_bus_addr"}, o_bus_address, 32'(0));
        chk({tag, "_bus_wdata"}, o_bus_wdata, 32'(0));
        chk({tag, "_grant"}, 32'(o_grant), 32'(0));
        chk({tag, "_ready"}, 32'(o_ready), 32'(0));
        chk({tag, "_fault"}, 32'(o_fault), 32'(0));
        for (int p = 0; p < NP; p++) chk({tag, "_rdata"}, o_rdata[p*32 +: 32], 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global time limit reached");
    end

    initial begin
        int n;
        i_reset     = 1'b0;
        i_request   = '0;
        i_rw        = '0;
        i_address   = '0;
        i_wdata     = '0;
        i_bus_ready = 1'b0;
        i_bus_rdata = '0;
        rearm       = '0;
        stray_en    = 1'b0;
        slv_cnt     = 0;
        for (int p = 0; p < NP; p++) reissue[p] = 0;

        repeat (2) tick();
        chk_all_zero("reset");
        i_reset = 1'b1;
        repeat (2) tick();

        // Ports 0 and 2 together; port 0 zero-wait. Stray slave ready outside BUSY must be ignored.
        stray_en = 1'b1;
        expect_txn(0, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h1111_0000, 32'h1111_0000, 1, 1'b0);
        expect_txn(2, 1'b0, 32'h0000_0200, 32'h0, 2, 32'h2222_0000, 32'h2222_0000, 2, 1'b0);
        raise(0, 1'b0, 32'h0000_0100, 32'h0, 0);
        raise(2, 1'b0, 32'h0000_0200, 32'h0, 0);
        wait_done("two_port_done", 200);
        stray_en = 1'b0;

        // Port 0 read, slave ready on the third request cycle.
        expect_txn(0, 1'b0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 1'b0);
        raise(0, 1'b0, 32'h0000_0010, 32'h0, 0);
        wait_done("read_done", 100);

        // Port 1 write.
        expect_txn(1, 1'b1, 32'h1000_0004, 32'h1234_5678, 4, 32'h0, 32'h0, 4, 1'b0);
        raise(1, 1'b1, 32'h1000_0004, 32'h1234_5678, 0);
        wait_done("write_done", 100);

        // Port 3 read to a dead address: watchdog completes with zero data and fault.
        expect_txn(3, 1'b0, 32'h5000_0000, 32'h0, 0, 32'hFFFF_FFFF, 32'h0, TO, 1'b1);
        raise(3, 1'b0, 32'h5000_0000, 32'h0, 0);
        wait_done("timeout_done", 100);

        // All ports continuously requesting: strict rotation 0,1,2,3 three times.
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < NP; p++) begin
                expect_txn(p, 1'b0, 32'h0000_4000 + 32'(p * 16), 32'h0, 1 + (p % 2),
                           32'hC0DE_0000 + 32'(r * 16 + p), 32'hC0DE_0000 + 32'(r * 16 + p),
                           1 + (p % 2), 1'b0);
            end
        end
        for (int p = 0; p < NP; p++) raise(p, 1'b0, 32'h0000_4000 + 32'(p * 16), 32'h0, 2);
        wait_done("fairness_done", 400);

        // Reset during BUSY abandons the transaction and restores port 0 priority.
        expect_txn(2, 1'b0, 32'h0000_2000, 32'h0, 0, 32'h0, 32'h0, TO, 1'b1);
        raise(2, 1'b0, 32'h0000_2000, 32'h0, 0);
        n = 0;
        while (!o_bus_request && n < 20) begin
            tick();
            n++;
        end
        chk_flag("mid_busy_reached", o_bus_request);
        repeat (4) tick();
        i_reset   = 1'b0;
        i_request = '0;
        rearm     = '0;
        for (int p = 0; p < NP; p++) reissue[p] = 0;
        exp_q.delete();
        tick();
        chk_all_zero("midrst");
        tick();
        i_reset = 1'b1;
        tick();
        expect_txn(0, 1'b0, 32'h0000_3000, 32'h0, 2, 32'h0000_AAAA, 32'h0000_AAAA, 2, 1'b0);
        expect_txn(3, 1'b0, 32'h0000_3300, 32'h0, 2, 32'h0000_3333, 32'h0000_3333, 2, 1'b0);
        raise(0, 1'b0, 32'h0000_3000, 32'h0, 0);
        raise(3, 1'b0, 32'h0000_3300, 32'h0, 0);
        wait_done("post_reset_done", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
